// File: rtl/psd_result_reader.sv
// PSD averaged-result reader: snapshots the four X/Y results on each averaging pulse
// and serves them to the ARM as a 13-word, 16-bit read stream, double-buffered against tearing.
module psd_chan_buf #(
  parameter int DATA_W = 36
) (
  input  logic              i_clk_1M,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] din,
  input  logic              ld_in,
  input  logic              ld_sh,
  input  logic              wr_sh,
  output logic [DATA_W-1:0] snap
);
  logic [DATA_W-1:0] shadow;

  always_ff @(posedge i_clk_1M or negedge i_rst_n) begin
    if (!i_rst_n) begin
      snap   <= '0;
      shadow <= '0;
    end else begin
      if (ld_in)      snap <= din;
      else if (ld_sh) snap <= shadow;
      if (wr_sh) shadow <= din;
    end
  end
endmodule

module psd_result_reader #(
  parameter int DATA_W = 36,
  parameter int BUS_W  = 16,
  parameter int SEQ_W  = 8
) (
  input  logic              i_clk_1M,
  input  logic              i_rst_n,
  input  logic              i_aver_flag,
  input  logic [DATA_W-1:0] i_A_X,
  input  logic [DATA_W-1:0] i_A_Y,
  input  logic [DATA_W-1:0] i_B_X,
  input  logic [DATA_W-1:0] i_B_Y,
  input  logic              i_rd_req,
  input  logic              i_rd_restart,
  input  logic              i_clr_ovr,
  output logic [BUS_W-1:0]  o_rd_data,
  output logic              o_rd_valid,
  output logic              o_rd_err,
  output logic              o_frame_ready,
  output logic              o_irq,
  output logic              o_overrun
);
  localparam int NCH   = 4;
  localparam int NWORD = 1 + 3 * NCH;

  typedef enum logic [1:0] {IDLE, READY, READING} state_t;

  state_t                        state, state_nxt;
  logic [NCH-1:0][DATA_W-1:0]    din, snap;
  logic [NWORD-1:0][BUS_W-1:0]   words;
  logic [3:0]                    idx, idx_eff;
  logic [SEQ_W-1:0]              seq;
  logic [7:0]                    status;
  logic                          pend, pend_nxt, ovr_nxt;
  logic                          serve, last, ld_in, ld_sh, wr_sh, ovr_set, irq_set;

  assign din = {i_B_Y, i_B_X, i_A_Y, i_A_X};

  for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
    logic [47:0] ext;
    psd_chan_buf #(.DATA_W(DATA_W)) u_buf (
      .i_clk_1M (i_clk_1M),
      .i_rst_n  (i_rst_n),
      .din      (din[ch]),
      .ld_in    (ld_in),
      .ld_sh    (ld_sh),
      .wr_sh    (wr_sh),
      .snap     (snap[ch])
    );
    assign ext             = 48'($signed(snap[ch]));
    assign words[1 + 3*ch] = snap[ch][15:0];
    assign words[2 + 3*ch] = snap[ch][31:16];
    assign words[3 + 3*ch] = ext[47:32];
  end
  assign words[0] = {seq, status};

  // Restart only rewinds an in-progress read; in other states idx is already 0.
  assign idx_eff = (state == READING && i_rd_restart) ? 4'd0 : idx;
  assign serve   = i_rd_req && (state != IDLE);
  assign last    = serve && (idx_eff == 4'(NWORD - 1));
  assign ovr_nxt = ovr_set ? 1'b1 : (i_clr_ovr ? 1'b0 : o_overrun);

  always_comb begin
    state_nxt = state;
    pend_nxt  = pend;
    ld_in     = 1'b0;
    ld_sh     = 1'b0;
    wr_sh     = 1'b0;
    ovr_set   = 1'b0;
    irq_set   = 1'b0;
    case (state)
      IDLE: if (i_aver_flag) begin
        ld_in     = 1'b1;
        irq_set   = 1'b1;
        state_nxt = READY;
      end
      READY: begin
        if (i_rd_req) begin
          // Read starts this cycle; a coincident frame must not tear it.
          state_nxt = READING;
          if (i_aver_flag) begin
            wr_sh    = 1'b1;
            pend_nxt = 1'b1;
          end
        end else if (i_aver_flag) begin
          ld_in   = 1'b1;
          ovr_set = 1'b1;
          irq_set = 1'b1;
        end
      end
      READING: begin
        if (last) begin
          pend_nxt = 1'b0;
          if (i_aver_flag) begin
            ld_in     = 1'b1;
            ovr_set   = pend;
            irq_set   = 1'b1;
            state_nxt = READY;
          end else if (pend) begin
            ld_sh     = 1'b1;
            irq_set   = 1'b1;
            state_nxt = READY;
          end else begin
            state_nxt = IDLE;
          end
        end else if (i_aver_flag) begin
          wr_sh    = 1'b1;
          pend_nxt = 1'b1;
          ovr_set  = pend;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk_1M or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= IDLE;
      idx           <= '0;
      pend          <= 1'b0;
      seq           <= '0;
      status        <= '0;
      o_rd_data     <= '0;
      o_rd_valid    <= 1'b0;
      o_rd_err      <= 1'b0;
      o_frame_ready <= 1'b0;
      o_irq         <= 1'b0;
      o_overrun     <= 1'b0;
    end else begin
      state         <= state_nxt;
      pend          <= pend_nxt;
      o_rd_valid    <= serve;
      o_rd_err      <= i_rd_req && (state == IDLE);
      o_irq         <= irq_set;
      o_overrun     <= ovr_nxt;
      o_frame_ready <= (state_nxt != IDLE);
      if (serve) begin
        o_rd_data <= words[idx_eff];
        idx       <= last ? 4'd0 : 4'(idx_eff + 4'd1);
      end else begin
        idx <= idx_eff;
      end
      if (ld_in || ld_sh) begin
        seq    <= seq + 1'b1;
        status <= {ovr_nxt, pend, 6'b0};
      end
    end
  end
endmodule

// File: tb/tb_psd_result_reader.sv
// Directed bench for psd_result_reader: cycle table of inputs/expected outputs,
// plus hand-written sequences for sequence wrap and reset mid-read.
`timescale 1ns/1ps
module tb_psd_result_reader;
  logic        i_clk_1M = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_aver_flag = 1'b0;
  logic [35:0] i_A_X = '0, i_A_Y = '0, i_B_X = '0, i_B_Y = '0;
  logic        i_rd_req = 1'b0, i_rd_restart = 1'b0, i_clr_ovr = 1'b0;
  logic [15:0] o_rd_data;
  logic        o_rd_valid, o_rd_err, o_frame_ready, o_irq, o_overrun;

  psd_result_reader dut (
    .i_clk_1M(i_clk_1M), .i_rst_n(i_rst_n), .i_aver_flag(i_aver_flag),
    .i_A_X(i_A_X), .i_A_Y(i_A_Y), .i_B_X(i_B_X), .i_B_Y(i_B_Y),
    .i_rd_req(i_rd_req), .i_rd_restart(i_rd_restart), .i_clr_ovr(i_clr_ovr),
    .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid), .o_rd_err(o_rd_err),
    .o_frame_ready(o_frame_ready), .o_irq(o_irq), .o_overrun(o_overrun)
  );

  always #500 i_clk_1M = ~i_clk_1M;

  typedef struct {
    string       nm;
    logic        rst, f, rd, rs, clr;
    logic [35:0] ax, ay, bx, by;
    logic [20:0] exp;  // {valid, data, err, ready, irq, ovr}
  } vec_t;

  vec_t        tab[$];
  logic [15:0] last_d = '0;
  int          n_vec = 0, n_err = 0;

  logic [15:0] w1[13] = '{16'h0100, 16'h1234, 16'h0000, 16'hFFF8, 16'h0001, 16'h0000, 16'h0000,
                          16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000};
  logic [15:0] w3[13] = '{16'h0280, 16'h8000, 16'h0000, 16'hFFFF, 16'h0002, 16'h0001, 16'h0000,
                          16'hFFFF, 16'hFFFF, 16'h0007, 16'h0000, 16'h0000, 16'hFFF8};
  logic [15:0] w4[13] = '{16'h0300, 16'h0044, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
                          16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0004, 16'h0000};
  logic [15:0] w5[13] = '{16'h0440, 16'h0055, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
                          16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
  logic [15:0] w6[13] = '{16'h0500, 16'h0066, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
                          16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hFFF9};
  logic [15:0] w7[13] = '{16'h0600, 16'h0077, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
                          16'h0099, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};

  function automatic void add(string nm, logic rst, logic f, logic [35:0] ax, logic [35:0] ay,
                              logic [35:0] bx, logic [35:0] by, logic rd, logic rs, logic clr,
                              logic v, logic [15:0] d, logic e, logic r, logic i, logic o);
    vec_t t;
    if (rst) last_d = '0;
    else if (v) last_d = d;
    t.nm = nm; t.rst = rst; t.f = f; t.rd = rd; t.rs = rs; t.clr = clr;
    t.ax = ax; t.ay = ay; t.bx = bx; t.by = by;
    t.exp = {v, last_d, e, r, i, o};
    tab.push_back(t);
  endfunction

  function automatic void fl(string nm, logic [35:0] ax, logic [35:0] ay, logic [35:0] bx,
                             logic [35:0] by, logic r, logic i, logic o);
    add(nm, 0, 1, ax, ay, bx, by, 0, 0, 0, 0, 16'h0, 0, r, i, o);
  endfunction

  function automatic void nop(string nm, logic r, logic o);
    add(nm, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0, 0, r, 0, o);
  endfunction

  function automatic void rd_frame(string nm, logic [15:0] w[13], int from, int to,
                                   logic lastr, logic lasti, logic o);
    for (int k = from; k <= to; k++)
      add($sformatf("%s_w%0d", nm, k), 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, w[k], 0,
          (k == 12) ? lastr : 1'b1, (k == 12) ? lasti : 1'b0, o);
  endfunction

  task automatic chk(string nm, logic [20:0] act, logic [20:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got v=%b d=%h e=%b rdy=%b irq=%b ovr=%b, want v=%b d=%h e=%b rdy=%b irq=%b ovr=%b",
               nm, act[20], act[19:4], act[3], act[2], act[1], act[0],
               exp[20], exp[19:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  function automatic logic [20:0] outs();
    return {o_rd_valid, o_rd_data, o_rd_err, o_frame_ready, o_irq, o_overrun};
  endfunction

  task automatic cyc(logic f, logic [35:0] ax, logic [35:0] ay, logic [35:0] bx, logic [35:0] by,
                     logic rd, logic rs, logic clr);
    @(negedge i_clk_1M);
    i_aver_flag = f; i_A_X = ax; i_A_Y = ay; i_B_X = bx; i_B_Y = by;
    i_rd_req = rd; i_rd_restart = rs; i_clr_ovr = clr;
    @(posedge i_clk_1M);
    #1;
    i_aver_flag = 0; i_rd_req = 0; i_rd_restart = 0; i_clr_ovr = 0;
  endtask

  task automatic do_reset();
    @(negedge i_clk_1M);
    i_rst_n = 0;
    @(posedge i_clk_1M);
    #1;
    chk("reset", outs(), 21'h0);
    i_rst_n = 1;
  endtask

  initial begin
    logic [15:0] w0_last;
    // ---- table construction ----
    add("rst0", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0, 0, 0, 0, 0);
    add("idle_rd", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 16'h0, 1, 0, 0, 0);
    nop("idle_nop", 0, 0);
    fl("f1", 36'h8_0000_1234, 36'h1, 36'hF_FFFF_FFFF, 36'h0, 1, 1, 0);
    nop("f1_nop", 1, 0);
    rd_frame("f1", w1, 0, 12, 0, 0, 0);
    add("rst1", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0, 0, 0, 0, 0);
    fl("f2", 36'h1_1111_1111, 0, 0, 0, 1, 1, 0);
    fl("f3_ovr", 36'hF_0000_8000, 36'h0_0001_0002, 36'h7_FFFF_FFFF, 36'h8_0000_0000, 1, 1, 1);
    rd_frame("f3", w3, 0, 12, 0, 0, 1);
    add("clr_ovr", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 16'h0, 0, 0, 0, 0);
    fl("f4", 36'h44, 0, 0, 36'h0_0004_0000, 1, 1, 0);
    rd_frame("f4a", w4, 0, 5, 0, 0, 0);
    fl("f5_mid", 36'h55, 0, 0, 0, 1, 0, 0);
    rd_frame("f4b", w4, 6, 12, 1, 1, 0);
    rd_frame("f5", w5, 0, 12, 0, 0, 0);
    fl("f6", 36'h66, 0, 0, 36'h9_0000_0000, 1, 1, 0);
    rd_frame("f6", w6, 0, 11, 0, 0, 0);
    add("coinc", 0, 1, 36'h77, 0, 36'h99, 0, 1, 0, 0, 1, w6[12], 0, 1, 1, 0);
    add("rs_ready", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 16'h0, 0, 1, 0, 0);
    rd_frame("f7a", w7, 0, 2, 0, 0, 0);
    add("restart_rd", 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, w7[0], 0, 1, 0, 0);
    rd_frame("f7b", w7, 1, 12, 0, 0, 0);

    // ---- table application ----
    foreach (tab[n]) begin
      if (tab[n].rst) begin
        do_reset();
      end else begin
        cyc(tab[n].f, tab[n].ax, tab[n].ay, tab[n].bx, tab[n].by, tab[n].rd, tab[n].rs, tab[n].clr);
        chk(tab[n].nm, outs(), tab[n].exp);
      end
    end

    // ---- 256 fully read frames: seq wraps to 0, no overrun ----
    do_reset();
    w0_last = 16'hDEAD;
    for (int f = 0; f < 256; f++) begin
      logic [7:0] s;
      s = 8'(f + 1);
      cyc(1, 36'(f), 0, 0, 0, 0, 0, 0);
      chk($sformatf("wrap_irq%0d", f), {o_frame_ready, o_irq, o_overrun, 18'h0}, {3'b110, 18'h0});
      for (int k = 0; k < 13; k++) begin
        cyc(0, 0, 0, 0, 0, 1, 0, 0);
        if (k == 0) begin
          chk($sformatf("wrap_w0_%0d", f), outs(), {1'b1, s, 8'h00, 4'b0100});
          w0_last = o_rd_data;
        end
        if (k == 1) chk($sformatf("wrap_w1_%0d", f), outs(), {1'b1, 16'(f), 4'b0100});
      end
      if (f == 255) chk("wrap_end", outs(), {1'b1, 16'h0000, 4'b0000});
    end
    chk("wrap_seq0", {w0_last, 5'h0}, {16'h0000, 5'h0});

    // ---- reset asserted mid-read ----
    cyc(1, 36'hA_BCDE_F012, 36'h5, 36'h6, 36'h7, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0, 0);
    chk("mid_w1", outs(), {1'b1, 16'hF012, 4'b0100});
    #200 i_rst_n = 0;
    #10;
    chk("mid_reset", outs(), 21'h0);
    #100 i_rst_n = 1;
    cyc(0, 0, 0, 0, 0, 1, 0, 0);
    chk("post_rst_idle", outs(), {1'b0, 16'h0, 4'b1000});
    cyc(1, 36'h3, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0, 0);
    chk("post_rst_seq1", outs(), {1'b1, 16'h0100, 4'b0100});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #60ms;
    $display("FAIL timeout: bench did not finish, want finish before 60ms");
    $fatal(1);
  end
endmodule
